ctrl_pipe: RTL and testbench
============================

Name: ctrl_pipe

Overview:
Consumer side of the main decoder's control bundle. It carries decoded control bits through the ID/EX, EX/MEM and MEM/WB pipeline registers, and detects load-use hazards, inserting one bubble for each. It resolves taken branches in EX and squashes the wrong-path instructions, and drives the forwarding selects for the EX-stage ALU operand muxes. Saturating stall and flush counters provide performance visibility.

Parameters:
CNT_W, 16, width of stall_cnt and flush_cnt.

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous, active-high reset
id_branch  in  1  decoded Branch for the instruction in ID
id_mem_read  in  1  decoded MemRead
id_mem_to_reg  in  1  decoded MemtoReg
id_mem_write  in  1  decoded MemWrite
id_alu_src  in  1  decoded ALUSrc
id_reg_write  in  1  decoded RegWrite
id_lui  in  1  decoded lui
id_alu_op  in  2  decoded ALUOp
id_valid  in  1  IF/ID register holds a real instruction
id_rs1, id_rs2, id_rd  in  5 each  register fields of the instruction in ID
ex_zero  in  1  ALU zero flag of the instruction in EX
ex_alu_src, ex_lui, ex_branch  out  1 each  ID/EX control outputs
ex_alu_op  out  2  ID/EX ALUOp
ex_valid  out  1  ID/EX holds a real instruction
mem_mem_read, mem_mem_write  out  1 each  EX/MEM control outputs
mem_reg_write, mem_mem_to_reg  out  1 each  EX/MEM control outputs
mem_rd  out  5  EX/MEM destination register
wb_reg_write, wb_mem_to_reg  out  1 each  MEM/WB control outputs
wb_rd  out  5  MEM/WB destination register
forward_a, forward_b  out  2 each  operand select: 00 register file, 10 EX/MEM result, 01 MEM/WB result
pc_write_en  out  1  PC may update
if_id_write_en  out  1  IF/ID may update
if_id_flush  out  1  clear IF/ID on the next edge
pc_src  out  1  select the branch target
stall_cnt, flush_cnt  out  CNT_W each  saturating event counters

Behaviour:
- Reset (asynchronous, rst=1): all stage registers clear. Every control output, rd, valid and counter is 0. Combinational outputs then evaluate to pc_write_en=1, if_id_write_en=1, if_id_flush=0, pc_src=0, forward_a/b=00.
- Stages: ID/EX holds the full bundle plus rs1, rs2, rd and valid. EX/MEM holds mem_read, mem_write, mem_to_reg, reg_write, rd and valid. MEM/WB holds mem_to_reg, reg_write, rd and valid.
- Bubble definition: valid=0 and every control bit 0. rd and rs fields are don't-care but are driven to 0.
- A load is mem_read=1 AND mem_to_reg=1. I-type ALU ops assert mem_read with mem_to_reg=0; they are not loads and never cause a stall.
- Load-use hazard (combinational), asserted when all of the following hold:
  - ex_valid and the ID/EX instruction is a load;
  - ID/EX rd != 0;
  - id_valid;
  - ID/EX rd == id_rs1 or ID/EX rd == id_rs2.
  - Effect: pc_write_en=0, if_id_write_en=0, and ID/EX loads a bubble on the next edge. The EX instruction advances normally.
  - Exactly one bubble is inserted per load-use pair.
- Branch: pc_src = ex_valid & ex_branch & ex_zero.
  - When pc_src=1: if_id_flush=1, ID/EX loads a bubble, pc_write_en=1, if_id_write_en=1.
  - Branch penalty is 2 cycles.
- Stall and branch in the same cycle: the branch wins. Flush is applied, the stall is suppressed, and only flush_cnt increments.
- EX/MEM and MEM/WB always advance; they are never stalled.
- Forwarding (per operand; forward_a compares the ID/EX rs1, forward_b the ID/EX rs2):
  - 10 when mem_reg_write & mem_rd!=0 & mem_rd==rs.
  - Otherwise 01 when wb_reg_write & wb_rd!=0 & wb_rd==rs.
  - Otherwise 00.
  - EX/MEM has priority over MEM/WB.
- Counters:
  - stall_cnt increments on each clock edge where a stall takes effect.
  - flush_cnt increments on each edge where pc_src=1.
  - Both saturate at all-ones; there is no wrap-around.
- Reset mid-operation: in-flight instructions are discarded and no writes are asserted in the reset cycle.
- Writeback latency: an ID-stage bundle appears at ex_* one edge later, mem_* two edges later and wb_* three edges later, absent stall or flush.

Test Plan:
- R-type (reg_write=1, alu_op=10, rd=5) with no hazards -> ex_alu_op=10 after 1 edge; mem_reg_write=1, mem_rd=5 after 2 edges; wb_reg_write=1, wb_rd=5 after 3 edges; no stalls.
- Load rd=7 followed by use with rs2=7 -> one cycle with pc_write_en=0 and if_id_write_en=0; ex_valid=0 on the next edge; then forward_b=01 for the dependent instruction; stall_cnt=1.
- I-type (mem_read=1, mem_to_reg=0) rd=7 followed by use with rs1=7 -> no stall; forward_a=10 when the dependent instruction is in EX.
- Branch in EX with ex_zero=1 -> pc_src=1 and if_id_flush=1 for one cycle; ID/EX becomes a bubble; flush_cnt=1. With ex_zero=0 -> no flush.
- Branch taken in the same cycle as a load-use hazard in ID -> flush occurs, stall is suppressed, stall_cnt unchanged.
- Additional checks:
  - rd=0 producer -> forward selects stay 00 and no stall.
  - rst pulsed mid-stream -> all outputs 0 immediately, asynchronously.
  - With CNT_W=2, force 5 stalls -> stall_cnt holds at 3.

Source files
------------

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: carries the decoded control bundle through ID/EX, EX/MEM and
// MEM/WB, inserts a single bubble on a load-use hazard, squashes the
// wrong-path instruction on a taken branch, selects ALU operand forwarding
// sources and counts stall/flush events with saturating counters.
module ctrl_pipe #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_branch,
   input  logic             id_mem_read,
   input  logic             id_mem_to_reg,
   input  logic             id_mem_write,
   input  logic             id_alu_src,
   input  logic             id_reg_write,
   input  logic             id_lui,
   input  logic [1:0]       id_alu_op,
   input  logic             id_valid,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic [4:0]       id_rd,
   input  logic             ex_zero,
   output logic             ex_alu_src,
   output logic             ex_lui,
   output logic             ex_branch,
   output logic [1:0]       ex_alu_op,
   output logic             ex_valid,
   output logic             mem_mem_read,
   output logic             mem_mem_write,
   output logic             mem_reg_write,
   output logic             mem_mem_to_reg,
   output logic [4:0]       mem_rd,
   output logic             wb_reg_write,
   output logic             wb_mem_to_reg,
   output logic [4:0]       wb_rd,
   output logic [1:0]       forward_a,
   output logic [1:0]       forward_b,
   output logic             pc_write_en,
   output logic             if_id_write_en,
   output logic             if_id_flush,
   output logic             pc_src,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   // ID/EX stage registers
   logic       r_ex_branch, r_ex_mem_read, r_ex_mem_to_reg, r_ex_mem_write;
   logic       r_ex_alu_src, r_ex_reg_write, r_ex_lui, r_ex_valid;
   logic [1:0] r_ex_alu_op;
   logic [4:0] r_ex_rs1, r_ex_rs2, r_ex_rd;

   // EX/MEM stage registers
   logic       r_mem_mem_read, r_mem_mem_write, r_mem_mem_to_reg, r_mem_reg_write, r_mem_valid;
   logic [4:0] r_mem_rd;

   // MEM/WB stage registers
   logic       r_wb_mem_to_reg, r_wb_reg_write, r_wb_valid;
   logic [4:0] r_wb_rd;

   logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

   logic w_load_use, w_pc_src, w_stall, w_bubble;

   // Hazard detection and branch resolution
   always_comb begin
      w_load_use = r_ex_valid && r_ex_mem_read && r_ex_mem_to_reg && (r_ex_rd != 5'd0) &&
                   id_valid && ((r_ex_rd == id_rs1) || (r_ex_rd == id_rs2));
      w_pc_src   = r_ex_valid && r_ex_branch && ex_zero;
      // A taken branch discards the ID instruction anyway, so it overrides the stall.
      w_stall    = w_load_use && !w_pc_src;
      // An empty IF/ID slot also enters ID/EX as a clean bubble.
      w_bubble   = w_stall || w_pc_src || !id_valid;
   end

   // ID/EX register: takes the ID bundle or a bubble
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ex_branch     <= 1'b0;
         r_ex_mem_read   <= 1'b0;
         r_ex_mem_to_reg <= 1'b0;
         r_ex_mem_write  <= 1'b0;
         r_ex_alu_src    <= 1'b0;
         r_ex_reg_write  <= 1'b0;
         r_ex_lui        <= 1'b0;
         r_ex_valid      <= 1'b0;
         r_ex_alu_op     <= 2'b00;
         r_ex_rs1        <= 5'd0;
         r_ex_rs2        <= 5'd0;
         r_ex_rd         <= 5'd0;
      end else if (w_bubble) begin
         // NOTE: non-blocking assignments here so every stage samples the
         // previous cycle's value of the stage ahead of it, regardless of
         // block ordering.
         r_ex_branch     <= 1'b0;
         r_ex_mem_read   <= 1'b0;
         r_ex_mem_to_reg <= 1'b0;
         r_ex_mem_write  <= 1'b0;
         r_ex_alu_src    <= 1'b0;
         r_ex_reg_write  <= 1'b0;
         r_ex_lui        <= 1'b0;
         r_ex_valid      <= 1'b0;
         r_ex_alu_op     <= 2'b00;
         r_ex_rs1        <= 5'd0;
         r_ex_rs2        <= 5'd0;
         r_ex_rd         <= 5'd0;
      end else begin
         r_ex_branch     <= id_branch;
         r_ex_mem_read   <= id_mem_read;
         r_ex_mem_to_reg <= id_mem_to_reg;
         r_ex_mem_write  <= id_mem_write;
         r_ex_alu_src    <= id_alu_src;
         r_ex_reg_write  <= id_reg_write;
         r_ex_lui        <= id_lui;
         r_ex_valid      <= 1'b1;
         r_ex_alu_op     <= id_alu_op;
         r_ex_rs1        <= id_rs1;
         r_ex_rs2        <= id_rs2;
         r_ex_rd         <= id_rd;
      end
   end

   // EX/MEM and MEM/WB registers: always advance, never stalled
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mem_mem_read   <= 1'b0;
         r_mem_mem_write  <= 1'b0;
         r_mem_mem_to_reg <= 1'b0;
         r_mem_reg_write  <= 1'b0;
         r_mem_valid      <= 1'b0;
         r_mem_rd         <= 5'd0;
         r_wb_mem_to_reg  <= 1'b0;
         r_wb_reg_write   <= 1'b0;
         r_wb_valid       <= 1'b0;
         r_wb_rd          <= 5'd0;
      end else begin
         r_mem_mem_read   <= r_ex_mem_read;
         r_mem_mem_write  <= r_ex_mem_write;
         r_mem_mem_to_reg <= r_ex_mem_to_reg;
         r_mem_reg_write  <= r_ex_reg_write;
         r_mem_valid      <= r_ex_valid;
         r_mem_rd         <= r_ex_rd;
         r_wb_mem_to_reg  <= r_mem_mem_to_reg;
         r_wb_reg_write   <= r_mem_reg_write;
         r_wb_valid       <= r_mem_valid;
         r_wb_rd          <= r_mem_rd;
      end
   end

   // Saturating performance counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (w_pc_src && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
   end

   // Forwarding selects: EX/MEM result beats MEM/WB result
   always_comb begin
      // NOTE: defaults first so every path assigns the outputs and no latch is inferred.
      forward_a = 2'b00;
      forward_b = 2'b00;
      if (wb_reg_write && (r_wb_rd != 5'd0) && (r_wb_rd == r_ex_rs1))    forward_a = 2'b01;
      if (mem_reg_write && (r_mem_rd != 5'd0) && (r_mem_rd == r_ex_rs1)) forward_a = 2'b10;
      if (wb_reg_write && (r_wb_rd != 5'd0) && (r_wb_rd == r_ex_rs2))    forward_b = 2'b01;
      if (mem_reg_write && (r_mem_rd != 5'd0) && (r_mem_rd == r_ex_rs2)) forward_b = 2'b10;
   end

   assign ex_alu_src     = r_ex_alu_src;
   assign ex_lui         = r_ex_lui;
   assign ex_branch      = r_ex_branch;
   assign ex_alu_op      = r_ex_alu_op;
   assign ex_valid       = r_ex_valid;
   assign mem_mem_read   = r_mem_mem_read   & r_mem_valid;
   assign mem_mem_write  = r_mem_mem_write  & r_mem_valid;
   assign mem_reg_write  = r_mem_reg_write  & r_mem_valid;
   assign mem_mem_to_reg = r_mem_mem_to_reg & r_mem_valid;
   assign mem_rd         = r_mem_rd;
   assign wb_reg_write   = r_wb_reg_write   & r_wb_valid;
   assign wb_mem_to_reg  = r_wb_mem_to_reg  & r_wb_valid;
   assign wb_rd          = r_wb_rd;
   assign pc_write_en    = !w_stall;
   assign if_id_write_en = !w_stall;
   assign if_id_flush    = w_pc_src;
   assign pc_src         = w_pc_src;
   assign stall_cnt      = r_stall_cnt;
   assign flush_cnt      = r_flush_cnt;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: table-driven pipeline latency checks through a due-cycle
// scoreboard, plus hand-written hazard, branch, reset and saturation sequences.
module tb_ctrl_pipe;

   logic clk = 1'b0;
   logic rst;
   logic id_branch, id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src;
   logic id_reg_write, id_lui, id_valid, ex_zero;
   logic [1:0] id_alu_op;
   logic [4:0] id_rs1, id_rs2, id_rd;

   logic ex_alu_src, ex_lui, ex_branch, ex_valid;
   logic [1:0] ex_alu_op;
   logic mem_mem_read, mem_mem_write, mem_reg_write, mem_mem_to_reg;
   logic [4:0] mem_rd, wb_rd;
   logic wb_reg_write, wb_mem_to_reg;
   logic [1:0] forward_a, forward_b;
   logic pc_write_en, if_id_write_en, if_id_flush, pc_src;
   logic [15:0] stall_cnt, flush_cnt;

   // second instance with narrow counters for the saturation check
   logic u2_ex_alu_src, u2_ex_lui, u2_ex_branch, u2_ex_valid;
   logic [1:0] u2_ex_alu_op;
   logic u2_mem_mem_read, u2_mem_mem_write, u2_mem_reg_write, u2_mem_mem_to_reg;
   logic [4:0] u2_mem_rd, u2_wb_rd;
   logic u2_wb_reg_write, u2_wb_mem_to_reg;
   logic [1:0] u2_forward_a, u2_forward_b;
   logic u2_pc_write_en, u2_if_id_write_en, u2_if_id_flush, u2_pc_src;
   logic [1:0] u2_stall_cnt, u2_flush_cnt;

   ctrl_pipe #(.CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .id_branch(id_branch), .id_mem_read(id_mem_read), .id_mem_to_reg(id_mem_to_reg),
      .id_mem_write(id_mem_write), .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
      .id_lui(id_lui), .id_alu_op(id_alu_op), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_zero(ex_zero),
      .ex_alu_src(ex_alu_src), .ex_lui(ex_lui), .ex_branch(ex_branch),
      .ex_alu_op(ex_alu_op), .ex_valid(ex_valid),
      .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
      .mem_reg_write(mem_reg_write), .mem_mem_to_reg(mem_mem_to_reg), .mem_rd(mem_rd),
      .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .wb_rd(wb_rd),
      .forward_a(forward_a), .forward_b(forward_b),
      .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en),
      .if_id_flush(if_id_flush), .pc_src(pc_src),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   ctrl_pipe #(.CNT_W(2)) dut2 (
      .clk(clk), .rst(rst),
      .id_branch(id_branch), .id_mem_read(id_mem_read), .id_mem_to_reg(id_mem_to_reg),
      .id_mem_write(id_mem_write), .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
      .id_lui(id_lui), .id_alu_op(id_alu_op), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_zero(ex_zero),
      .ex_alu_src(u2_ex_alu_src), .ex_lui(u2_ex_lui), .ex_branch(u2_ex_branch),
      .ex_alu_op(u2_ex_alu_op), .ex_valid(u2_ex_valid),
      .mem_mem_read(u2_mem_mem_read), .mem_mem_write(u2_mem_mem_write),
      .mem_reg_write(u2_mem_reg_write), .mem_mem_to_reg(u2_mem_mem_to_reg), .mem_rd(u2_mem_rd),
      .wb_reg_write(u2_wb_reg_write), .wb_mem_to_reg(u2_wb_mem_to_reg), .wb_rd(u2_wb_rd),
      .forward_a(u2_forward_a), .forward_b(u2_forward_b),
      .pc_write_en(u2_pc_write_en), .if_id_write_en(u2_if_id_write_en),
      .if_id_flush(u2_if_id_flush), .pc_src(u2_pc_src),
      .stall_cnt(u2_stall_cnt), .flush_cnt(u2_flush_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic       br, mr, m2r, mw, as, rw, lui;
      logic [1:0] op;
      logic [4:0] rd;
      logic [5:0] exp_ex;   // {valid, alu_op, alu_src, lui, branch}
      logic [8:0] exp_mem;  // {mem_read, mem_write, reg_write, mem_to_reg, rd}
      logic [6:0] exp_wb;   // {reg_write, mem_to_reg, rd}
   } vec_t;

   typedef struct {
      int         due;
      int         stage;
      logic [8:0] exp;
      string      name;
   } sb_t;

   vec_t vecs[6];
   sb_t  sb[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [8:0] stage_val(input int stage);
      case (stage)
         0:       return {3'b000, ex_valid, ex_alu_op, ex_alu_src, ex_lui, ex_branch};
         1:       return {mem_mem_read, mem_mem_write, mem_reg_write, mem_mem_to_reg, mem_rd};
         default: return {2'b00, wb_reg_write, wb_mem_to_reg, wb_rd};
      endcase
   endfunction

   // advance one edge, then compare any scoreboard entries due this cycle
   task automatic step();
      @(posedge clk);
      cyc++;
      #1;
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].due == cyc) begin
            check(sb[i].name, 32'(stage_val(sb[i].stage)), 32'(sb[i].exp));
            sb.delete(i);
         end
      end
   endtask

   task automatic set_id(input logic br, input logic mr, input logic m2r, input logic mw,
                         input logic as, input logic rw, input logic lui, input logic [1:0] op,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
      id_branch = br; id_mem_read = mr; id_mem_to_reg = m2r; id_mem_write = mw;
      id_alu_src = as; id_reg_write = rw; id_lui = lui; id_alu_op = op;
      id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_valid = 1'b1;
   endtask

   task automatic idle();
      id_branch = 0; id_mem_read = 0; id_mem_to_reg = 0; id_mem_write = 0;
      id_alu_src = 0; id_reg_write = 0; id_lui = 0; id_alu_op = 2'b00;
      id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_valid = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      //          name      br mr m2r mw as rw lui op     rd     ex          mem                 wb
      vecs[0] = '{"rtype",  0, 0, 0,  0, 0, 1, 0,  2'b10, 5'd5,  6'b110000, 9'b0_0_1_0_00101, 7'b1_0_00101};
      vecs[1] = '{"load",   0, 1, 1,  0, 1, 1, 0,  2'b00, 5'd7,  6'b100100, 9'b1_0_1_1_00111, 7'b1_1_00111};
      vecs[2] = '{"store",  0, 0, 0,  1, 1, 0, 0,  2'b00, 5'd3,  6'b100100, 9'b0_1_0_0_00011, 7'b0_0_00011};
      vecs[3] = '{"itype",  0, 1, 0,  0, 1, 1, 0,  2'b11, 5'd12, 6'b111100, 9'b1_0_1_0_01100, 7'b1_0_01100};
      vecs[4] = '{"lui",    0, 0, 0,  0, 1, 1, 1,  2'b00, 5'd31, 6'b100110, 9'b0_0_1_0_11111, 7'b1_0_11111};
      vecs[5] = '{"branch", 1, 0, 0,  0, 0, 0, 0,  2'b01, 5'd0,  6'b101001, 9'b0_0_0_0_00000, 7'b0_0_00000};

      idle();
      ex_zero = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ex_valid", 32'(ex_valid), 0);
      check("rst_mem_reg_write", 32'(mem_reg_write), 0);
      check("rst_wb_rd", 32'(wb_rd), 0);
      check("rst_pc_write_en", 32'(pc_write_en), 1);
      check("rst_if_id_write_en", 32'(if_id_write_en), 1);
      check("rst_if_id_flush", 32'(if_id_flush), 0);
      check("rst_pc_src", 32'(pc_src), 0);
      check("rst_forward", 32'({forward_a, forward_b}), 0);
      check("rst_counters", 32'({stall_cnt, flush_cnt}), 0);
      rst = 1'b0;

      // table: one instruction followed by bubbles, checked at EX, MEM, WB
      foreach (vecs[k]) begin
         set_id(vecs[k].br, vecs[k].mr, vecs[k].m2r, vecs[k].mw, vecs[k].as, vecs[k].rw,
                vecs[k].lui, vecs[k].op, 5'd1, 5'd2, vecs[k].rd);
         sb.push_back('{cyc + 1, 0, {3'b000, vecs[k].exp_ex}, {vecs[k].name, "_ex"}});
         sb.push_back('{cyc + 2, 1, vecs[k].exp_mem, {vecs[k].name, "_mem"}});
         sb.push_back('{cyc + 3, 2, {2'b00, vecs[k].exp_wb}, {vecs[k].name, "_wb"}});
         step();
         idle();
         step();
         step();
      end
      check("scoreboard_drained", 32'(sb.size()), 0);
      check("table_no_stall", 32'(stall_cnt), 0);
      check("table_no_flush", 32'(flush_cnt), 0);

      // load rd=7 then use rs2=7: one stall, then MEM/WB forwarding on b
      set_id(0, 1, 1, 0, 1, 1, 0, 2'b00, 5'd1, 5'd2, 5'd7);
      step();
      set_id(0, 0, 0, 0, 0, 1, 0, 2'b10, 5'd3, 5'd7, 5'd8);
      #1;
      check("lu_pc_write_en", 32'(pc_write_en), 0);
      check("lu_if_id_write_en", 32'(if_id_write_en), 0);
      step();
      check("lu_bubble", 32'(ex_valid), 0);
      check("lu_stall_cnt", 32'(stall_cnt), 1);
      check("lu_single_bubble", 32'(pc_write_en), 1);
      step();
      check("lu_use_in_ex", 32'(ex_valid), 1);
      check("lu_forward_b", 32'(forward_b), 32'(2'b01));
      check("lu_forward_a", 32'(forward_a), 0);
      idle();
      step();

      // I-type rd=7 then use rs1=7: no stall, EX/MEM forwarding on a
      set_id(0, 1, 0, 0, 1, 1, 0, 2'b11, 5'd1, 5'd2, 5'd7);
      step();
      set_id(0, 0, 0, 0, 0, 1, 0, 2'b10, 5'd7, 5'd0, 5'd8);
      #1;
      check("itype_no_stall", 32'(pc_write_en), 1);
      step();
      check("itype_forward_a", 32'(forward_a), 32'(2'b10));
      check("itype_stall_cnt", 32'(stall_cnt), 1);
      idle();
      step();

      // two producers of r9: EX/MEM wins over MEM/WB
      set_id(0, 0, 0, 0, 0, 1, 0, 2'b10, 5'd1, 5'd2, 5'd9);
      step();
      set_id(0, 0, 0, 0, 0, 1, 0, 2'b10, 5'd3, 5'd4, 5'd9);
      step();
      set_id(0, 0, 0, 0, 0, 1, 0, 2'b10, 5'd9, 5'd9, 5'd10);
      step();
      check("prio_forward_a", 32'(forward_a), 32'(2'b10));
      check("prio_forward_b", 32'(forward_b), 32'(2'b10));
      idle();
      step();
      check("wb_only_forward_a", 32'(forward_a), 0);
      step();

      // taken branch: flush for one cycle, ID/EX becomes a bubble
      set_id(1, 0, 0, 0, 0, 0, 0, 2'b01, 5'd1, 5'd2, 5'd0);
      step();
      ex_zero = 1'b1;
      set_id(0, 0, 0, 0, 0, 1, 0, 2'b10, 5'd1, 5'd2, 5'd11);
      #1;
      check("br_pc_src", 32'(pc_src), 1);
      check("br_if_id_flush", 32'(if_id_flush), 1);
      check("br_pc_write_en", 32'({pc_write_en, if_id_write_en}), 32'(2'b11));
      step();
      check("br_bubble", 32'(ex_valid), 0);
      check("br_flush_cnt", 32'(flush_cnt), 1);
      check("br_one_cycle", 32'({pc_src, if_id_flush}), 0);
      ex_zero = 1'b0;
      idle();
      step();

      // not-taken branch: no flush
      set_id(1, 0, 0, 0, 0, 0, 0, 2'b01, 5'd1, 5'd2, 5'd0);
      step();
      set_id(0, 0, 0, 0, 0, 1, 0, 2'b10, 5'd1, 5'd2, 5'd11);
      #1;
      check("nt_pc_src", 32'({pc_src, if_id_flush}), 0);
      step();
      check("nt_ex_valid", 32'(ex_valid), 1);
      check("nt_flush_cnt", 32'(flush_cnt), 1);
      idle();
      step();

      // branch and load-use in the same cycle: branch wins
      set_id(1, 1, 1, 0, 0, 1, 0, 2'b01, 5'd1, 5'd2, 5'd4);
      step();
      ex_zero = 1'b1;
      set_id(0, 0, 0, 0, 0, 1, 0, 2'b10, 5'd4, 5'd5, 5'd6);
      #1;
      check("both_pc_src", 32'(pc_src), 1);
      check("both_no_stall", 32'({pc_write_en, if_id_write_en}), 32'(2'b11));
      step();
      check("both_stall_cnt", 32'(stall_cnt), 1);
      check("both_flush_cnt", 32'(flush_cnt), 2);
      check("both_bubble", 32'(ex_valid), 0);
      ex_zero = 1'b0;
      idle();
      step();

      // rd=0 load producer: no stall, no forwarding
      set_id(0, 1, 1, 0, 1, 1, 0, 2'b00, 5'd1, 5'd2, 5'd0);
      step();
      set_id(0, 0, 0, 0, 0, 1, 0, 2'b10, 5'd0, 5'd0, 5'd8);
      #1;
      check("rd0_no_stall", 32'(pc_write_en), 1);
      step();
      check("rd0_forward", 32'({forward_a, forward_b}), 0);
      check("rd0_stall_cnt", 32'(stall_cnt), 1);
      idle();
      step();

      // asynchronous reset between clock edges
      set_id(0, 0, 0, 0, 0, 1, 0, 2'b10, 5'd1, 5'd2, 5'd5);
      step();
      idle();
      step();
      check("pre_rst_mem_reg_write", 32'(mem_reg_write), 1);
      #3 rst = 1'b1;
      #1;
      check("arst_mem", 32'({mem_reg_write, mem_rd}), 0);
      check("arst_ex_valid", 32'(ex_valid), 0);
      check("arst_wb", 32'({wb_reg_write, wb_rd}), 0);
      check("arst_counters", 32'({stall_cnt, flush_cnt}), 0);
      sb.delete();
      @(posedge clk);
      #1 rst = 1'b0;

      // five load-use stalls: narrow counter saturates at 3
      for (int n = 1; n <= 5; n++) begin
         set_id(0, 1, 1, 0, 1, 1, 0, 2'b00, 5'd1, 5'd2, 5'd7);
         step();
         set_id(0, 0, 0, 0, 0, 1, 0, 2'b10, 5'd7, 5'd3, 5'd8);
         step();
         idle();
         step();
         if (n == 3) check("sat_cnt_at_3", 32'(u2_stall_cnt), 3);
      end
      check("sat_cnt_held", 32'(u2_stall_cnt), 3);
      check("wide_cnt_5", 32'(stall_cnt), 5);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
